instr_encoder: RTL and testbench

Encoder counterpart to the main/ALU control decode path. It takes symbolic instruction requests (kind plus register, immediate and target fields) over a valid/ready handshake. It assembles 32-bit MIPS words and streams them into instruction memory at consecutive word addresses. It is used by the bench and boot logic to load programs into imem before the pipelined core runs.

---
 rtl/instr_encoder.sv | 89 ++++++++
 tb/tb_instr_encoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: assembles MIPS words from symbolic requests and streams them into imem
module instr_encoder #(
    parameter int DEPTH = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_word,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_kind,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err_illegal
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] wrPtr;
    logic [5:0]    funct;
    logic [5:0]    opcode;
    logic [31:0]   encWord;
    logic          legal;
    logic          accept;

    always_comb begin
        funct = 6'h20;
        opcode = 6'h00;
        case (in_kind)
            4'd1: funct = 6'h22;
            4'd2: funct = 6'h24;
            4'd3: funct = 6'h25;
            4'd4: funct = 6'h2A;
            4'd5: opcode = 6'h23;
            4'd6: opcode = 6'h2B;
            4'd7: opcode = 6'h04;
            4'd8: opcode = 6'h08;
            default: ;
        endcase
    end

    assign encWord = in_kind == 4'd9 ? {6'h02, in_target}
                   : in_kind < 4'd5  ? {6'h00, in_rs, in_rt, in_rd, 5'd0, funct}
                   :                   {opcode, in_rs, in_rt, in_imm};
    assign legal    = in_kind <= 4'd9;
    assign in_ready = state == LOAD && !start;
    assign full     = state == FULL;
    assign accept   = in_valid && in_ready;

    // start takes priority; in_ready is forced low that cycle, so no accept collides with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wrPtr       <= '0;
            count       <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            err_illegal <= 1'b0;
        end else begin
            mem_we <= accept && legal;
            if (accept && legal) begin
                mem_addr  <= {{(30-AW){1'b0}}, wrPtr, 2'b00};
                mem_wdata <= encWord;
                wrPtr     <= wrPtr + AW'(1);
                count     <= count + (AW+1)'(1);
                if (count == (AW+1)'(DEPTH-1)) state <= FULL;
            end
            if (accept && !legal) err_illegal <= 1'b1;
            if (start) begin
                state       <= LOAD;
                wrPtr       <= base_word;
                count       <= '0;
                err_illegal <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed stimulus against a transaction-level model of the loader
module tb_instr_encoder;
    localparam int DEPTH = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_word = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_kind = '0;
    logic [4:0]    in_rs = '0;
    logic [4:0]    in_rt = '0;
    logic [4:0]    in_rd = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err_illegal;

    int nChecks = 0;
    int nErrors = 0;

    bit          mOpen, mFull, mErr, mWe;
    int          mPtr, mCnt;
    logic [31:0] mAddr, mData;

    instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_word(base_word),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .full(full), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] refEnc(input int kind, input int rs, input int rt,
                                           input int rd, input int imm, input int tgt);
        int functs[5] = '{32, 34, 36, 37, 42};
        int ops[4] = '{35, 43, 4, 8};
        longint w;
        if (kind < 5) w = longint'(rs) * 2097152 + rt * 65536 + rd * 2048 + functs[kind];
        else if (kind == 9) w = 2 * 67108864 + longint'(tgt);
        else w = longint'(ops[kind-5]) * 67108864 + longint'(rs) * 2097152 + rt * 65536 + imm;
        return 32'(w);
    endfunction

    task automatic step();
        bit rdy, acc;
        #1;
        rdy = mOpen && !mFull && !start;
        check("in_ready", 32'(in_ready), 32'(rdy));
        if (reset) begin
            {mOpen, mFull, mErr, mWe} = '0;
            mPtr = 0; mCnt = 0; mAddr = 0; mData = 0;
        end else begin
            acc = rdy && in_valid;
            mWe = 0;
            if (acc && in_kind < 10) begin
                mWe = 1;
                mAddr = mPtr * 4;
                mData = refEnc(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
                mPtr = (mPtr + 1) % DEPTH;
                mCnt++;
                if (mCnt == DEPTH) mFull = 1;
            end else if (acc) mErr = 1;
            if (start) begin
                mOpen = 1; mFull = 0; mErr = 0; mPtr = base_word; mCnt = 0;
            end
        end
        @(posedge clk);
        #1;
        check("mem_we", 32'(mem_we), 32'(mWe));
        check("mem_addr", mem_addr, mAddr);
        check("mem_wdata", mem_wdata, mData);
        check("count", 32'(count), 32'(mCnt));
        check("full", 32'(full), 32'(mFull));
        check("err_illegal", 32'(err_illegal), 32'(mErr));
    endtask

    task automatic idle();
        reset = 0; start = 0; in_valid = 0;
        step();
    endtask

    task automatic go(input int b, input bit v);
        reset = 0; start = 1; base_word = AW'(b); in_valid = v; in_kind = 0;
        step();
        start = 0;
    endtask

    task automatic req(input int k, input int rs, input int rt, input int rd, input int imm, input int tgt);
        reset = 0; start = 0; in_valid = 1; in_kind = 4'(k);
        in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_imm = 16'(imm); in_target = 26'(tgt);
        step();
        in_valid = 0;
    endtask

    task automatic randReq(input int illegalPct);
        int k;
        k = ($urandom_range(99) < illegalPct) ? $urandom_range(15, 10) : $urandom_range(9);
        req(k, $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step();
        idle();
        go(0, 1);
        req(0, 1, 2, 3, 0, 0);
        check("add_word", mem_wdata, 32'h00221820);
        check("add_count", 32'(count), 32'd1);
        req(5, 9, 8, 0, 4, 0);
        req(6, 9, 8, 0, 8, 0);
        check("sw_word", mem_wdata, 32'hAD280008);
        req(7, 1, 2, 0, 16'hFFFF, 0);
        check("beq_word", mem_wdata, 32'h1022FFFF);
        req(9, 0, 0, 0, 0, 26'h100);
        check("j_word", mem_wdata, 32'h08000100);
        req(8, 0, 2, 0, 5, 0);
        check("addi_word", mem_wdata, 32'h20020005);
        req(12, 1, 1, 1, 1, 1);
        check("illegal_we", 32'(mem_we), 32'd0);
        idle();
        req(0, 4, 5, 6, 0, 0);
        check("after_illegal_addr", mem_addr, 32'h18);
        req(5, 1, 2, 0, 3, 0);
        go(5, 1);
        idle();
        go(62, 0);
        for (int i = 0; i < DEPTH; i++) begin
            req($urandom_range(9), $urandom, $urandom, $urandom, $urandom, $urandom);
            if (i == 2) check("wrap_addr", mem_addr, 32'h0);
        end
        check("full_set", 32'(full), 32'd1);
        randReq(0);
        idle();
        go(3, 0);
        check("full_cleared", 32'(full), 32'd0);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(99);
            if (r < 2) begin
                reset = 1; start = 0; in_valid = 1;
                step();
                reset = 0;
            end else if (r < 7) go($urandom, $urandom_range(1));
            else if (r < 30) idle();
            else randReq(10);
        end
        go(10, 0);
        req(0, 1, 2, 3, 0, 0);
        reset = 1; in_valid = 1; in_kind = 0;
        step();
        check("reset_we", 32'(mem_we), 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        reset = 0; in_valid = 0;
        idle();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
